// File: rtl/ps2_frame_receiver_if.sv
// Consumer-side bundle of ps2_frame_receiver.
// Carries the scan-code FIFO head, the ready flag and the active-low pop strobe.
// It also carries the sticky overflow flag and the rejected-frame counter.
// The receiver uses the master modport; the scan-code consumer uses the slave modport.
interface ps2_frame_receiver_if;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic [7:0] err_count;

    modport master (
        input  nextdata_n,
        output data,
        output ready,
        output overflow,
        output err_count
    );

    modport slave (
        output nextdata_n,
        input  data,
        input  ready,
        input  overflow,
        input  err_count
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver with a scan-code FIFO.
// The raw ps2_clk/ps2_data lines are synchronised into clk.
// Each 11-bit frame is deserialised: start, d0..d7, odd parity, stop.
// Frames with a good stop bit are buffered for the downstream consumer.
// Optional macro PS2_PARITY_CHECK_EN enables two things:
//   - odd-parity checking of each frame;
//   - a saturating counter of rejected frames on err_count.
module ps2_frame_receiver #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_frame_receiver_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t        state, state_next;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          ps2_edge;
    logic          bit_in;
    logic [9:0]    shreg;
    logic [3:0]    bitcnt;
    logic [TW-1:0] tcnt;
    logic          start_frame, shift_en, check_frame, tmo_clr, tmo_inc;
    logic          frame_ok;
    logic          push_valid;
    logic [7:0]    push_byte;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr, wptr_n, rptr_n;
    logic          full, pop, do_push;
    logic [7:0]    data_r;
    logic          ready_r, overflow_r;

    // The falling edge is seen once s2 is still high and s1 has dropped.
    // Data runs two stages deep so that it lines up with s1.
    assign ps2_edge = clk_sync[2] & ~clk_sync[1];
    assign bit_in   = data_sync[1];

    // Synchronise both PS/2 lines into the system clock domain.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '0;
            data_sync <= '0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_next;
    end

    // Frame FSM next-state and control strobes.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        check_frame = 1'b0;
        tmo_clr     = 1'b1;
        tmo_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (ps2_edge && !bit_in) begin
                    start_frame = 1'b1;
                    state_next  = RECV;
                end
            end
            RECV: begin
                tmo_clr = ps2_edge;
                tmo_inc = !ps2_edge;
                if (ps2_edge) begin
                    shift_en = 1'b1;
                    if (bitcnt == 4'd10) state_next = CHECK;
                end else if (tcnt == TMO_LAST) begin
                    state_next = IDLE;
                end
            end
            CHECK: begin
                check_frame = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift data bits in LSB first; the start bit itself is not kept.
    // The bit counter and the mid-frame idle counter also live here.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shreg  <= '0;
            bitcnt <= '0;
            tcnt   <= '0;
        end else begin
            if (start_frame)   bitcnt <= 4'd1;
            else if (shift_en) bitcnt <= bitcnt + 4'd1;
            if (shift_en) shreg <= {bit_in, shreg[9:1]};
            if (tmo_clr)      tcnt <= '0;
            else if (tmo_inc) tcnt <= tcnt + 1'b1;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic [7:0] err_cnt;

    // Odd parity: d0..d7 XOR the parity bit must come out as 1.
    assign frame_ok = shreg[9] & (^shreg[8:0]);

    // Count rejected frames, saturating at 255.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                                      err_cnt <= '0;
        else if (check_frame && !frame_ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

    assign bus.err_count = err_cnt;
`else
    assign frame_ok      = shreg[9];
    assign bus.err_count = 8'h00;
`endif

    // Register an accepted byte for one write cycle ahead of the FIFO.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            push_valid <= 1'b0;
            push_byte  <= '0;
        end else begin
            push_valid <= check_frame & frame_ok;
            push_byte  <= shreg[7:0];
        end
    end

    // ready always mirrors "pointers differ", so it alone qualifies a pop.
    // A push into a full FIFO still lands if a pop frees a slot the same cycle.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = ~bus.nextdata_n & ready_r;
    assign do_push = push_valid & (~full | pop);
    assign wptr_n  = wptr + {{AW{1'b0}}, do_push};
    assign rptr_n  = rptr + {{AW{1'b0}}, pop};

    // FIFO storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_byte;
    end

    // Pointers, the registered head byte and the flags.
    // The head is looked ahead from the next pointers, so data follows a pop immediately.
    // When the head slot is being written this cycle, the byte is forwarded.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr       <= '0;
            rptr       <= '0;
            data_r     <= '0;
            ready_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wptr    <= wptr_n;
            rptr    <= rptr_n;
            ready_r <= (wptr_n != rptr_n);
            if (wptr_n != rptr_n) begin
                if (do_push && rptr_n == wptr) data_r <= push_byte;
                else                           data_r <= mem[rptr_n[AW-1:0]];
            end
            if (push_valid && full && !pop) overflow_r <= 1'b1;
        end
    end

    assign bus.data     = data_r;
    assign bus.ready    = ready_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed self-checking bench for ps2_frame_receiver.
// The default build has PS2_PARITY_CHECK_EN undefined.
// The bad-parity expectations follow the same macro.
module tb_ps2_frame_receiver;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic r4, r5;

    ps2_frame_receiver_if bus_if ();

    ps2_frame_receiver #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus_if.master)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit with 5-cycle high and 5-cycle low phases.
    // The final low phase is left to the caller.
    task automatic send_bit(input logic b, input logic last);
        @(negedge clk);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        if (!last) begin
            repeat (5) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    // Full frame. ready is sampled 4 and 5 cycles after the stop-bit fall.
    // A pop can optionally coincide with the FIFO write cycle.
    task automatic apply_stimulus(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                                  input logic pop_at_write, output logic rdy4, output logic rdy5);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i], i == 10);
        repeat (4) @(negedge clk);
        rdy4 = bus_if.ready;
        if (pop_at_write) bus_if.nextdata_n = 1'b0;
        @(negedge clk);
        rdy5 = bus_if.ready;
        bus_if.nextdata_n = 1'b1;
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        logic a, c;
        apply_stimulus(b, 1'b0, 1'b0, 1'b0, a, c);
    endtask

    // Send the first n bits of a valid frame, then leave the line high.
    task automatic send_partial(input logic [7:0] b, input int n);
        logic [10:0] bits;
        bits = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < n; i++) send_bit(bits[i], 1'b0);
    endtask

    task automatic pop_one;
        @(negedge clk);
        bus_if.nextdata_n = 1'b0;
        @(negedge clk);
        bus_if.nextdata_n = 1'b1;
    endtask

    // Directed sequence.
    initial begin
        logic [7:0] exp_q [$];
        bus_if.nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_data", bus_if.data, 8'h00);
        check_output("reset_ready", {7'd0, bus_if.ready}, 8'h00);
        check_output("reset_overflow", {7'd0, bus_if.overflow}, 8'h00);
        check_output("reset_err", bus_if.err_count, 8'h00);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] single frame 1C");
        apply_stimulus(8'h1C, 1'b0, 1'b0, 1'b0, r4, r5);
        check_output("lat_ready_at4", {7'd0, r4}, 8'h00);
        check_output("lat_ready_at5", {7'd0, r5}, 8'h01);
        check_output("data_1C", bus_if.data, 8'h1C);
        pop_one();
        check_output("ready_after_pop", {7'd0, bus_if.ready}, 8'h00);

        $display("[TB] back to back F0 1C");
        send_frame(8'hF0);
        send_frame(8'h1C);
        check_output("head_F0", bus_if.data, 8'hF0);
        pop_one();
        check_output("head_1C", bus_if.data, 8'h1C);
        check_output("ready_one_left", {7'd0, bus_if.ready}, 8'h01);
        pop_one();
        check_output("ready_drained", {7'd0, bus_if.ready}, 8'h00);

        $display("[TB] bad parity 5A and bad stop 33");
        apply_stimulus(8'h5A, 1'b1, 1'b0, 1'b0, r4, r5);
`ifdef PS2_PARITY_CHECK_EN
        check_output("badpar_ready", {7'd0, bus_if.ready}, 8'h00);
        check_output("badpar_err", bus_if.err_count, 8'h01);
`else
        check_output("badpar_ready", {7'd0, bus_if.ready}, 8'h01);
        check_output("badpar_data", bus_if.data, 8'h5A);
        pop_one();
        check_output("badpar_err", bus_if.err_count, 8'h00);
`endif
        apply_stimulus(8'h33, 1'b0, 1'b1, 1'b0, r4, r5);
        check_output("badstop_ready", {7'd0, bus_if.ready}, 8'h00);
`ifdef PS2_PARITY_CHECK_EN
        check_output("badstop_err", bus_if.err_count, 8'h02);
`else
        check_output("badstop_err", bus_if.err_count, 8'h00);
`endif

        $display("[TB] timeout then 29");
        send_partial(8'hA5, 5);
        repeat (TMO + 10) @(negedge clk);
        send_frame(8'h29);
        check_output("tmo_data", bus_if.data, 8'h29);
        pop_one();
        check_output("tmo_only_one", {7'd0, bus_if.ready}, 8'h00);

        $display("[TB] overflow");
        for (int i = 1; i <= 8; i++) send_frame(8'(i));
        check_output("ovf_before", {7'd0, bus_if.overflow}, 8'h00);
        send_frame(8'h09);
        check_output("ovf_after", {7'd0, bus_if.overflow}, 8'h01);
        check_output("ovf_head", bus_if.data, 8'h01);
        pop_one();
        send_frame(8'h0A);
        apply_stimulus(8'h0B, 1'b0, 1'b0, 1'b1, r4, r5);
        exp_q = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};
        foreach (exp_q[i]) begin
            check_output($sformatf("drain_%0d", i), bus_if.data, exp_q[i]);
            pop_one();
        end
        check_output("drain_empty", {7'd0, bus_if.ready}, 8'h00);

        $display("[TB] reset mid-frame");
        send_frame(8'h11);
        send_frame(8'h22);
        send_frame(8'h33);
        send_partial(8'h44, 6);
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        check_output("rst_data", bus_if.data, 8'h00);
        check_output("rst_ready", {7'd0, bus_if.ready}, 8'h00);
        check_output("rst_overflow", {7'd0, bus_if.overflow}, 8'h00);
        check_output("rst_err", bus_if.err_count, 8'h00);
        @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h12);
        check_output("post_rst_data", bus_if.data, 8'h12);
        pop_one();
        check_output("post_rst_empty", {7'd0, bus_if.ready}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
